cordic_engine: RTL and testbench
================================

// Module: cordic_engine
// PURPOSE
// - Iterative CORDIC engine, one micro-rotation per clock. mode 0 = rotation, mode 1 = vectoring.
// - Rotation rotates vector (x,y) by angle z. Vectoring returns magnitude and angle of (x,y).
// - I/O words are 16-bit sign-magnitude Q7.8: bit15 = sign, bits14:0 = |value|*256, angles in radians.
// - Free-running: re-samples inputs and recomputes continuously. Used as a trig/polar math unit.
// PARAMETERS
// - W      16  I/O word width (sign + 7 int + 8 frac)
// - FRAC   8   fractional bits of I/O words
// - GW     24  internal two's-complement datapath width (guard bits: 4 int, 4 frac)
// - ITER   16  number of micro-rotations
// PORTS
// - clk    in   1   rising-edge clock
// - reset  in   1   asynchronous, active-low reset
// - mode   in   1   0 = rotation, 1 = vectoring; sampled in LOAD
// - x      in   16  x operand, sign-magnitude Q7.8
// - y      in   16  y operand, sign-magnitude Q7.8
// - z      in   16  angle in radians, sign-magnitude Q7.8; ignored in vectoring
// - res1   out  16  rotation: x*cos z - y*sin z; vectoring: sqrt(x^2+y^2)
// - res2   out  16  rotation: x*sin z + y*cos z; vectoring: atan2(y,x) in (-pi,pi]
// BEHAVIOUR
// - Clocking and reset: one clock. reset is asynchronous and active-low.
// - While reset=0: res1=res2=0, internal regs=0, FSM=LOAD, iteration counter=0. Reset mid-computation aborts it.
// - FSM: LOAD -> ITER (ITER cycles, i=0..15) -> DONE -> LOAD.
//   - A frame is 18 cycles; res1/res2 update once per frame.
// - LOAD: register mode; convert x, y, z from sign-magnitude to GW-bit two's complement. -0 is treated as 0.
//   Then apply the quadrant pre-rotation:
//   - Rotation: if z > pi/2, then (x,y,z) <= (-y, x, z-pi/2). If z < -pi/2, then (x,y,z) <= (y, -x, z+pi/2).
//   - Vectoring: if x < 0, then (x,y) <= (-x, -y) and z0 <= +pi (y>=0) or -pi (y<0). Otherwise z0 = 0.
// - ITER step i, with d = +1 or -1:
//   - x' = x - d*(y>>>i); y' = y + d*(x>>>i); z' = z - d*atan(2^-i).
//   - Rotation: d = sign(z), +1 when z >= 0. Vectoring: d = -sign(y), +1 when y < 0.
//   - Shifts are arithmetic. atan table holds 16 constants in GW-bit fixed point.
// - DONE: gain compensation multiplies x and y by K = 0.607253. Rotation outputs (x,y); vectoring outputs (x,z).
//   - Round to nearest at FRAC, saturate |value| to 0x7FFF, convert to sign-magnitude, register into res1/res2.
//   - 0 is output as 0x0000, never 0x8000.
// - Inputs changing mid-frame have no effect until the next LOAD.
// - Accuracy: each output within +-4 LSB (+-0.0156) of the exact real result for in-range results.
// STRUCTURE
// - Package cordic_pkg: ATAN_TABLE[0:15], K_GAIN, PI, HALF_PI constants (GW-bit); mode and FSM-state enums.
// - Sub-module cordic_sm_conv: combinational sign-magnitude <-> two's-complement converter with saturation.
//   - Instantiated 3x on input, 2x on output.
// - Top: FSM, iteration counter, x/y/z registers, shifters, adders, one gain multiplier.
// TESTING
// - Reset: hold reset=0 for 10 ns -> res1=res2=0x0000; first result appears 18 cycles after release.
// - Rotation: mode=0, x=0x9994 (-25.578125), y=0x1EC1 (30.75390625), z=0x01DF (1.87109375)
//   -> res1 ~ -21.81 (0x95CF +-4), res2 ~ -33.53 (0xA188 +-4).
// - Vectoring: mode=1, same x,y -> res1 ~ 40.00 (0x2800 +-4), res2 ~ 2.2645 (0x0243 +-4).
// - Identity: mode=0, x=0x0100 (1.0), y=0, z=0 -> res1 = 0x0100 +-2, res2 = 0x0000 +-2.
// - Saturation: mode=0, x=y=0x7FFF, z=0x00C9 (pi/4) -> res2 = 0x7FFF (clipped), res1 ~ 0.
// - Mid-frame: change x during ITER -> next result unaffected; async reset in ITER -> outputs clear immediately.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared constants and types for the iterative CORDIC engine.
// Angles and datapath values are GW-bit two's complement with 12 fractional bits.
package cordic_pkg;

  localparam int GW_PKG = 24;
  localparam int ZFRAC  = 12;
  localparam int K_FRAC = 16;

  typedef logic signed [GW_PKG-1:0] gw_t;

  // atan(2^-i) scaled by 2^12
  localparam gw_t ATAN_TABLE [0:15] = '{
    24'sd3217, 24'sd1899, 24'sd1003, 24'sd509,
    24'sd256,  24'sd128,  24'sd64,   24'sd32,
    24'sd16,   24'sd8,    24'sd4,    24'sd2,
    24'sd1,    24'sd0,    24'sd0,    24'sd0
  };

  // K scaled by 2^16; PI and HALF_PI scaled by 2^12
  localparam gw_t K_GAIN  = 24'sd39797;
  localparam gw_t PI      = 24'sd12868;
  localparam gw_t HALF_PI = 24'sd6434;

  typedef enum logic {
    MODE_ROT = 1'b0,
    MODE_VEC = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cordic_sm_conv.sv
// Combinational converter between sign-magnitude I/O words and the
// two's-complement datapath; the output direction rounds and saturates.
module cordic_sm_conv #(
  parameter int W     = 16,
  parameter int GW    = 24,
  parameter int SHIFT = 4,
  parameter bit TO_SM = 1'b0
) (
  input  logic [(TO_SM ? GW : W)-1:0] din,
  output logic [(TO_SM ? W : GW)-1:0] dout
);

  generate
    if (TO_SM) begin : g_to_sm
      logic [GW-1:0]  mag;
      logic [GW-1:0]  rnd;
      logic [W-2:0]   mag_sat;
      always_comb begin
        mag     = din[GW-1] ? -din : din;
        rnd     = (mag + (GW'(1) << (SHIFT - 1))) >> SHIFT;
        mag_sat = (rnd > GW'(2**(W-1) - 1)) ? '1 : rnd[W-2:0];
        // a zero magnitude always leaves as +0
        dout    = (mag_sat == '0) ? '0 : {din[GW-1], mag_sat};
      end
    end else begin : g_to_tc
      logic [GW-1:0] mag;
      always_comb begin
        mag  = {{(GW-W+1-SHIFT){1'b0}}, din[W-2:0], {SHIFT{1'b0}}};
        dout = din[W-1] ? -mag : mag;
      end
    end
  endgenerate

endmodule

// File: rtl/cordic_engine.sv
// Free-running iterative CORDIC: LOAD, ITER micro-rotations, DONE.
// Rotation mode rotates (x,y) by z; vectoring mode yields magnitude and atan2.
module cordic_engine
  import cordic_pkg::*;
#(
  parameter int W    = 16,
  parameter int FRAC = 8,
  parameter int GW   = GW_PKG,
  parameter int ITER = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         mode,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  output logic [W-1:0] res1,
  output logic [W-1:0] res2
);

  localparam int CW    = $clog2(ITER);
  localparam int SHIFT = ZFRAC - FRAC;

  state_e        state;
  logic [CW-1:0] cnt;
  mode_e         mode_r;
  gw_t           x_acc, y_acc, z_acc;
  gw_t           x_tc, y_tc, z_tc;
  gw_t           x_sh, y_sh;
  gw_t           x_gain, y_gain, res2_src;
  logic          d_pos;
  logic [W-1:0]  res1_nxt, res2_nxt;

  function automatic gw_t apply_gain(input gw_t v);
    logic signed [2*GW-1:0] p;
    p = (2*GW)'(v) * (2*GW)'(K_GAIN);
    p = p + (2*GW)'(1 <<< (K_FRAC - 1));
    return p[K_FRAC +: GW];
  endfunction

  cordic_sm_conv #(.W(W), .GW(GW), .SHIFT(SHIFT), .TO_SM(1'b0)) u_conv_x (.din(x), .dout(x_tc));
  cordic_sm_conv #(.W(W), .GW(GW), .SHIFT(SHIFT), .TO_SM(1'b0)) u_conv_y (.din(y), .dout(y_tc));
  cordic_sm_conv #(.W(W), .GW(GW), .SHIFT(SHIFT), .TO_SM(1'b0)) u_conv_z (.din(z), .dout(z_tc));

  always_comb begin
    x_sh     = x_acc >>> cnt;
    y_sh     = y_acc >>> cnt;
    d_pos    = (mode_r == MODE_ROT) ? !z_acc[GW-1] : y_acc[GW-1];
    x_gain   = apply_gain(x_acc);
    y_gain   = apply_gain(y_acc);
    res2_src = (mode_r == MODE_VEC) ? z_acc : y_gain;
  end

  cordic_sm_conv #(.W(W), .GW(GW), .SHIFT(SHIFT), .TO_SM(1'b1)) u_conv_r1 (.din(x_gain),   .dout(res1_nxt));
  cordic_sm_conv #(.W(W), .GW(GW), .SHIFT(SHIFT), .TO_SM(1'b1)) u_conv_r2 (.din(res2_src), .dout(res2_nxt));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_LOAD;
      cnt    <= '0;
      mode_r <= MODE_ROT;
      x_acc  <= '0;
      y_acc  <= '0;
      z_acc  <= '0;
      res1   <= '0;
      res2   <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          mode_r <= mode_e'(mode);
          cnt    <= '0;
          state  <= ST_ITER;
          // quadrant pre-rotation brings the problem into CORDIC's convergence range
          if (mode_e'(mode) == MODE_VEC) begin
            if (x_tc[GW-1]) begin
              x_acc <= -x_tc;
              y_acc <= -y_tc;
              z_acc <= y_tc[GW-1] ? -PI : PI;
            end else begin
              x_acc <= x_tc;
              y_acc <= y_tc;
              z_acc <= '0;
            end
          end else if (z_tc > HALF_PI) begin
            x_acc <= -y_tc;
            y_acc <= x_tc;
            z_acc <= z_tc - HALF_PI;
          end else if (z_tc < -HALF_PI) begin
            x_acc <= y_tc;
            y_acc <= -x_tc;
            z_acc <= z_tc + HALF_PI;
          end else begin
            x_acc <= x_tc;
            y_acc <= y_tc;
            z_acc <= z_tc;
          end
        end
        ST_ITER: begin
          if (d_pos) begin
            x_acc <= x_acc - y_sh;
            y_acc <= y_acc + x_sh;
            z_acc <= z_acc - ATAN_TABLE[cnt];
          end else begin
            x_acc <= x_acc + y_sh;
            y_acc <= y_acc - x_sh;
            z_acc <= z_acc + ATAN_TABLE[cnt];
          end
          if (cnt == CW'(ITER - 1)) begin
            cnt   <= '0;
            state <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          res1  <= res1_nxt;
          res2  <= res2_nxt;
          state <= ST_LOAD;
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_engine.sv
// Directed bench for cordic_engine: hand-computed vectors checked with tolerance.
module tb_cordic_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] x = '0, y = '0, z = '0;
  logic [15:0] res1, res2;
  int          tests = 0;
  int          fails = 0;

  cordic_engine dut (
    .clk  (clk),
    .reset(reset),
    .mode (mode),
    .x    (x),
    .y    (y),
    .z    (z),
    .res1 (res1),
    .res2 (res2)
  );

  always #5 clk = ~clk;

  function automatic int sm2int(input logic [15:0] v);
    return v[15] ? -int'(v[14:0]) : int'(v[14:0]);
  endfunction

  task automatic check_exact(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input logic [15:0] obs, input logic [15:0] exp,
                            input int tol);
    int   diff;
    logic ok;
    diff = sm2int(obs) - sm2int(exp);
    ok   = !$isunknown(obs) && (diff <= tol) && (diff >= -tol);
    tests++;
    assert (ok === 1'b1) else begin
      fails++;
      $error("FAIL %s: got %h expected %h +-%0d", tag, obs, exp, tol);
    end
  endtask

  // inputs are applied just after DONE so the next edge is LOAD
  task automatic frame(input logic m, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c);
    mode = m;
    x    = a;
    y    = b;
    z    = c;
    repeat (18) @(posedge clk);
    #1;
  endtask

  initial begin
    mode = 1'b0; x = 16'h9994; y = 16'h1EC1; z = 16'h01DF;
    #12;
    check_exact("reset_res1", res1, 16'h0000);
    check_exact("reset_res2", res2, 16'h0000);
    @(negedge clk);
    reset = 1'b1;

    repeat (17) @(posedge clk);
    #1;
    check_exact("latency_res1", res1, 16'h0000);
    check_exact("latency_res2", res2, 16'h0000);
    @(posedge clk);
    #1;
    check_near("rot_res1", res1, 16'h95CF, 4);
    check_near("rot_res2", res2, 16'hA188, 4);

    frame(1'b1, 16'h9994, 16'h1EC1, 16'h0000);
    check_near("vec_mag", res1, 16'h2800, 4);
    check_near("vec_ang", res2, 16'h0243, 4);

    frame(1'b0, 16'h0100, 16'h0000, 16'h0000);
    check_near("ident_res1", res1, 16'h0100, 2);
    check_near("ident_res2", res2, 16'h0000, 2);

    frame(1'b0, 16'h7FFF, 16'h7FFF, 16'h00C9);
    check_exact("sat_res2", res2, 16'h7FFF);
    check_near("sat_res1", res1, 16'h000B, 48);

    frame(1'b0, 16'h0100, 16'h0000, 16'h8200);
    check_near("negz_res1", res1, 16'h806A, 4);
    check_near("negz_res2", res2, 16'h80E9, 4);

    frame(1'b1, 16'h8300, 16'h8400, 16'h0000);
    check_near("vec3_mag", res1, 16'h0500, 4);
    check_near("vec3_ang", res2, 16'h8237, 4);

    frame(1'b1, 16'h8000, 16'h0200, 16'h0000);
    check_near("negzero_mag", res1, 16'h0200, 4);
    check_near("negzero_ang", res2, 16'h0192, 4);

    frame(1'b0, 16'h8000, 16'h8000, 16'h8100);
    check_exact("zero_res1", res1, 16'h0000);
    check_exact("zero_res2", res2, 16'h0000);

    mode = 1'b0; x = 16'h0100; y = 16'h0000; z = 16'h0000;
    repeat (5) @(posedge clk);
    x    = 16'h7FFF;
    mode = 1'b1;
    repeat (13) @(posedge clk);
    #1;
    check_near("midframe_res1", res1, 16'h0100, 2);
    check_near("midframe_res2", res2, 16'h0000, 2);

    mode = 1'b0; x = 16'h9994; y = 16'h1EC1; z = 16'h01DF;
    repeat (6) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check_exact("async_rst_res1", res1, 16'h0000);
    check_exact("async_rst_res2", res2, 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    repeat (18) @(posedge clk);
    #1;
    check_near("post_rst_res1", res1, 16'h95CF, 4);
    check_near("post_rst_res2", res2, 16'hA188, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
